// File: rtl/mdl.sv
// Register-bank operation unit: DEPTH x WIDTH scratch store with addressed/pointer ops, one registered response per command.
// Optional MDL_SAT_INC_EN: INC saturates at all-ones and flags overflow through rsp_err.
module mdl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [AW-1:0]    ptr
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SHR2 = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_READ = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_WPTR = 3'b101;
  localparam logic [2:0] OP_RPTR = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             addr_ok;
  logic [WIDTH-1:0] cur;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_val;
  logic             clr;
  logic             rsp_fire;
  logic [WIDTH-1:0] rsp_data_n;
  logic             rsp_err_n;
  logic [AW-1:0]    ptr_n;

  assign accept  = cmd_valid && cmd_ready;
  assign addr_ok = {1'b0, cmd_addr} < DEPTH_W;
  assign cur     = addr_ok ? mem[cmd_addr] : '0;

  always_comb begin
    wr_en      = 1'b0;
    wr_idx     = cmd_addr;
    wr_val     = '0;
    clr        = 1'b0;
    rsp_fire   = 1'b0;
    rsp_data_n = '0;
    rsp_err_n  = 1'b0;
    ptr_n      = ptr;
    if (accept && cmd_op != OP_NOP) begin
      rsp_fire = 1'b1;
      // Addressed ops with an out-of-range address only return an error.
      if (!addr_ok && (cmd_op == OP_SHR2 || cmd_op == OP_LOAD ||
                       cmd_op == OP_READ || cmd_op == OP_INC)) begin
        rsp_err_n = 1'b1;
      end else begin
        unique case (cmd_op)
          OP_SHR2: begin
            wr_en      = 1'b1;
            wr_val     = cur >> 2;
            rsp_data_n = cur >> 2;
          end
          OP_LOAD: begin
            wr_en      = 1'b1;
            wr_val     = cmd_data;
            rsp_data_n = cmd_data;
          end
          OP_READ: rsp_data_n = cur;
          OP_INC: begin
`ifdef MDL_SAT_INC_EN
            if (&cur) begin
              rsp_data_n = cur;
              rsp_err_n  = 1'b1;
            end else begin
              wr_en      = 1'b1;
              wr_val     = cur + 1'b1;
              rsp_data_n = cur + 1'b1;
            end
`else
            wr_en      = 1'b1;
            wr_val     = cur + 1'b1;
            rsp_data_n = cur + 1'b1;
`endif
          end
          OP_WPTR: begin
            wr_en      = 1'b1;
            wr_idx     = ptr;
            wr_val     = cmd_data;
            rsp_data_n = cmd_data;
            ptr_n      = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
          end
          OP_RPTR: rsp_data_n = mem[ptr];
          OP_CLR: begin
            clr   = 1'b1;
            ptr_n = '0;
          end
          default: rsp_fire = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr       <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_data <= rsp_data_n;
        rsp_err  <= rsp_err_n;
      end
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
        mem[wr_idx] <= wr_val;
      end
      ptr <= ptr_n;
    end
  end

endmodule

// File: tb/tb_mdl.sv
// Directed bench for mdl: commands driven on the falling edge, responses checked one falling edge later.
module tb_mdl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [2:0] ptr;

  int tests_run;
  int tests_failed;

  mdl #(.WIDTH(8), .DEPTH(5), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command at the current falling edge; the response is checked at the next one.
  task automatic send(input string tag, input logic [2:0] op, input logic [2:0] addr,
                      input logic [7:0] data, input logic [7:0] exp_data, input logic exp_err);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clk);
    check({tag, ".vld"}, 32'(rsp_valid), 32'd1);
    check({tag, ".dat"}, 32'(rsp_data), 32'(exp_data));
    check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  task automatic idle(input string tag);
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    @(negedge clk);
    check({tag, ".novld"}, 32'(rsp_valid), 32'd0);
  endtask

  logic [7:0] exp_inc;
  logic       exp_inc_err;
  logic [7:0] vals [5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_addr  = 3'd0;
    cmd_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst.ready", 32'(cmd_ready), 32'd0);
    check("rst.vld",   32'(rsp_valid), 32'd0);
    check("rst.dat",   32'(rsp_data),  32'd0);
    check("rst.err",   32'(rsp_err),   32'd0);
    check("rst.ptr",   32'(ptr),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy.up", 32'(cmd_ready), 32'd1);

    send("load2", 3'b010, 3'd2, 8'hB4, 8'hB4, 1'b0);
    send("read2", 3'b011, 3'd2, 8'h00, 8'hB4, 1'b0);
    idle("idle1");
    check("hold.dat", 32'(rsp_data), 32'hB4);

    send("load0", 3'b010, 3'd0, 8'hB4, 8'hB4, 1'b0);
    send("shr_a", 3'b001, 3'd0, 8'h00, 8'h2D, 1'b0);
    send("shr_b", 3'b001, 3'd0, 8'h00, 8'h0B, 1'b0);

`ifdef MDL_SAT_INC_EN
    exp_inc = 8'hFF; exp_inc_err = 1'b1;
`else
    exp_inc = 8'h00; exp_inc_err = 1'b0;
`endif
    send("load1", 3'b010, 3'd1, 8'hFF, 8'hFF, 1'b0);
    send("inc1",  3'b100, 3'd1, 8'h00, exp_inc, exp_inc_err);
    send("rd1",   3'b011, 3'd1, 8'h00, exp_inc, 1'b0);
    send("inc2",  3'b100, 3'd2, 8'h00, 8'hB5, 1'b0);
    idle("idle2");

    // Six pointer writes wrap the pointer 4 -> 0 and overwrite entry 0.
    for (int i = 1; i <= 6; i++) begin
      send($sformatf("wptr%0d", i), 3'b101, 3'd7, 8'(i), 8'(i), 1'b0);
      check($sformatf("ptr%0d", i), 32'(ptr), (i == 5) ? 32'd0 : (i == 6) ? 32'd1 : 32'(i));
    end
    send("rd0", 3'b011, 3'd0, 8'h00, 8'h06, 1'b0);
    send("rd4", 3'b011, 3'd4, 8'h00, 8'h05, 1'b0);

    send("bad_rd5", 3'b011, 3'd5, 8'h00, 8'h00, 1'b1);
    send("bad_ld7", 3'b010, 3'd7, 8'h11, 8'h00, 1'b1);
    send("bad_inc6", 3'b100, 3'd6, 8'h00, 8'h00, 1'b1);
    vals[0] = 8'h06; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04; vals[4] = 8'h05;
    for (int i = 0; i < 5; i++)
      send($sformatf("chk%0d", i), 3'b011, 3'(i), 8'h00, vals[i], 1'b0);
    send("rptr", 3'b110, 3'd0, 8'h00, 8'h02, 1'b0);
    check("rptr.ptr", 32'(ptr), 32'd1);
    idle("nop_pre");
    cmd_valid = 1'b1;
    cmd_op    = 3'b000;
    @(negedge clk);
    check("nop.vld", 32'(rsp_valid), 32'd0);
    check("nop.ptr", 32'(ptr), 32'd1);

    send("load3", 3'b010, 3'd3, 8'h5A, 8'h5A, 1'b0);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("rstp.vld", 32'(rsp_valid), 32'd0);
    check("rstp.dat", 32'(rsp_data),  32'd0);
    check("rstp.ptr", 32'(ptr),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send("rd3", 3'b011, 3'd3, 8'h00, 8'h00, 1'b0);

    send("ld0", 3'b010, 3'd0, 8'h77, 8'h77, 1'b0);
    send("ld4", 3'b010, 3'd4, 8'h88, 8'h88, 1'b0);
    send("wp",  3'b101, 3'd0, 8'h99, 8'h99, 1'b0);
    check("wp.ptr", 32'(ptr), 32'd1);
    send("clr", 3'b111, 3'd0, 8'hAA, 8'h00, 1'b0);
    check("clr.ptr", 32'(ptr), 32'd0);
    for (int i = 0; i < 5; i++)
      send($sformatf("clr_rd%0d", i), 3'b011, 3'(i), 8'h00, 8'h00, 1'b0);
    idle("end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
